spi_slave_responder: RTL and testbench
======================================

# spi_slave_responder

SPI slave (responder) companion to the team's SPI master peripheral block. It receives one DATA_WIDTH command word from the master and returns a preloaded 2×DATA_WIDTH reply across two SS-framed words. Mode 0 only (CPOL=0, CPHA=0). SCK, SS and MOSI are oversampled in the spi_clk_i domain. It sits on the peripheral/emulation side of the bootstrap fabric and lets us loop-test the master without external hardware.

## Interface
- DATA_WIDTH, 8: bits per SPI word.
- TIMEOUT_CYC, 64: spi_clk_i cycles SS may stay high between word0 and word1 before the transaction is abandoned.

- spi_clk_i  in  1  master clock; all logic is on its posedge.
- spi_rst_i  in  1  reset, asynchronous, active-high.
- SCK_SPI  in  1  SPI clock from the master; asynchronous to the block.
- SS  in  1  slave select, active-low, asynchronous.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial data to the master; 1'b1 whenever SS is high or the block is disabled.
- spi_enable_i  in  1  1 = respond to frames, 0 = ignore the bus.
- spi_fbo_i  in  1  bit order: 1 = MSB first, 0 = LSB first. Sampled at each word start.
- spi_txdata_i  in  2*DATA_WIDTH  reply; [2W-1:W] is sent in word0, [W-1:0] in word1.
- spi_txload_i  in  1  loads spi_txdata_i into the reply register when spi_txready_o=1.
- spi_txready_o  out  1  high in IDLE only.
- spi_rxdata_o  out  DATA_WIDTH  last received command word.
- spi_rxvalid_o  out  1  one-cycle pulse when spi_rxdata_o updates.
- spi_doneflag_o  out  1  one-cycle pulse when word1 completes.
- spi_frameerr_o  out  1  one-cycle pulse on an aborted word or a timeout.

## Operation
- Synchronization:
  - SCK, SS and MOSI each pass through a 2-flop synchronizer plus one edge-detect flop.
  - Edges are acted on 3 cycles after the pin change.
- States: IDLE, WORD0, GAP, WORD1, DONE.
  - **IDLE:** spi_txload_i copies spi_txdata_i into the reply register.
    - On SS fall with spi_enable_i=1: go to WORD0, clear the bit counter, drive the first reply bit on MISO.
  - **WORD0:**
    - On each SCK rise: shift MOSI into the rx shift register and increment the bit counter.
    - On each SCK fall: present the next reply bit.
    - On SS rise with count==DATA_WIDTH: spi_rxdata_o <= shift register, pulse spi_rxvalid_o, go to GAP.
    - On SS rise with count!=DATA_WIDTH: pulse spi_frameerr_o, go to IDLE, spi_rxdata_o unchanged.
  - **GAP:** count cycles while SS is high.
    - On SS fall: go to WORD1.
    - On reaching TIMEOUT_CYC: pulse spi_frameerr_o, go to IDLE.
  - **WORD1:** shifts as in WORD0 using the reply low half; MOSI data is discarded.
    - On SS rise with a full count: go to DONE.
    - On SS rise with a short count: pulse spi_frameerr_o, go to IDLE.
  - **DONE:** pulse spi_doneflag_o, return to IDLE next cycle.
- spi_enable_i low mid-transaction: finish the current word, then go to IDLE without error.
- Bit order:
  - MSB first (spi_fbo_i=1): shift left, MOSI enters at bit 0, MISO takes the top bit.
  - LSB first (spi_fbo_i=0): shift right, MOSI enters at the top bit, MISO takes bit 0.
- The reply register is retained across transactions. An unloaded transaction resends the previous reply.

## Timing
- Reset values:
  - MISO=1, spi_txready_o=1; spi_rxvalid_o, spi_doneflag_o, spi_frameerr_o = 0.
  - spi_rxdata_o=0, reply register all ones, state IDLE.
- Reset mid-transaction returns the block to IDLE immediately. No pulses are emitted.
- Each SCK half-period must be ≥4 spi_clk_i cycles (master divider 1:4 or slower).
- MISO changes 3–4 cycles after SCK fall. It is stable before the next SCK rise.
- spi_rxvalid_o is asserted 4 cycles after SS rises at the end of word0.
- spi_doneflag_o is asserted 5 cycles after SS rises at the end of word1.
- spi_txload_i coincident with an SS fall in IDLE: the load wins, and word0 transmits the newly loaded data.

## Configuration
- SPI_SLAVE_OVERRUN_EN defined:
  - Adds input spi_rxack_i (1 bit), which clears a "pending" flag.
  - Adds output spi_overrun_o, a one-cycle pulse when a word0 completes while pending is still set.
  - spi_rxdata_o is overwritten anyway.
- Not defined: neither port exists and no pending flag is kept.

## Structure
- Package spi_pkg holds:
  - The state encoding (IDLE=3'd0, WORD0=3'd1, GAP=3'd2, WORD1=3'd3, DONE=3'd4).
  - The FBO_MSB/FBO_LSB constants.
- Sub-module spi_slave_sync provides a 2-flop synchronizer with rise/fall pulse outputs. It is instantiated for SCK, SS and MOSI; for MOSI only the synchronized level output is used.

## Test plan
- Reply 16'hA55A loaded, spi_fbo_i=1, master sends cmd 8'h3C at 1:4 -> spi_rxdata_o=8'h3C with one rxvalid pulse; master receives 16'hA55A; one spi_doneflag_o pulse.
- Same test with spi_fbo_i=0 and cmd 8'h01 -> spi_rxdata_o=8'h01; master receives 16'hA55A.
- SS rises after 5 bits of word0 -> spi_frameerr_o pulses, spi_rxdata_o unchanged, state IDLE, next full frame succeeds.
- SS held high 64 cycles after word0 -> spi_frameerr_o pulses, no doneflag, spi_txready_o=1.
- spi_rst_i asserted mid-word1 -> MISO=1, all pulses 0, state IDLE; spi_txload_i accepted the next cycle.
- With SPI_SLAVE_OVERRUN_EN: two transactions without spi_rxack_i -> spi_overrun_o pulses once; spi_rxdata_o holds the second command.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg -- shared constants for the SPI slave responder.
//   State encoding of the responder FSM (IDLE, WORD0, GAP, WORD1, DONE)
//   and the bit-order selector values for spi_fbo_i.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WORD0 = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_WORD1 = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic FBO_MSB = 1'b1;
  localparam logic FBO_LSB = 1'b0;

  // True while an SS-framed word is being shifted.
  function automatic logic state_is_word(input logic [2:0] st);
    return (st == ST_WORD0) || (st == ST_WORD1);
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync -- 2-flop synchronizer with one edge-detect flop.
//   spi_clk_i  : sampling clock
//   spi_rst_i  : asynchronous, active-high reset (all flops to RST_VAL)
//   i_async    : asynchronous input pin
//   o_level    : synchronized level
//   o_rise     : one-cycle pulse on a synchronized 0->1 transition
//   o_fall     : one-cycle pulse on a synchronized 1->0 transition
// A pin change shows up on o_rise/o_fall after two clock edges, so logic
// registering on those pulses acts on the third edge.
module spi_slave_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic spi_clk_i,
  input  logic spi_rst_i,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder -- SPI mode-0 slave that takes one command word and
// returns a preloaded two-word reply in two SS-framed words.
//   spi_clk_i, spi_rst_i     : clock / async active-high reset
//   SCK_SPI, SS, MOSI, MISO  : SPI pins (SS active-low, MISO idles at 1)
//   spi_enable_i             : respond to frames when 1
//   spi_fbo_i                : bit order, 1 = MSB first (latched per word)
//   spi_txdata_i/spi_txload_i: reply value / load strobe (IDLE only)
//   spi_txready_o            : high in IDLE
//   spi_rxdata_o/_rxvalid_o  : last command word / update pulse
//   spi_doneflag_o           : pulse when word1 completes
//   spi_frameerr_o           : pulse on short word or gap timeout
//   o_dbg_state              : current FSM state (spi_pkg encoding)
// Optional feature macro SPI_SLAVE_OVERRUN_EN adds spi_rxack_i and
// spi_overrun_o (command overwritten before it was acknowledged).
//
// Handshake: spi_rxvalid_o is a one-cycle strobe with no back-pressure;
// spi_rxdata_o holds the word until the next completed word0.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    spi_clk_i,
  input  logic                    spi_rst_i,
  input  logic                    SCK_SPI,
  input  logic                    SS,
  input  logic                    MOSI,
  output logic                    MISO,
  input  logic                    spi_enable_i,
  input  logic                    spi_fbo_i,
  input  logic [2*DATA_WIDTH-1:0] spi_txdata_i,
  input  logic                    spi_txload_i,
  output logic                    spi_txready_o,
  output logic [DATA_WIDTH-1:0]   spi_rxdata_o,
  output logic                    spi_rxvalid_o,
  output logic                    spi_doneflag_o,
  output logic                    spi_frameerr_o,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                    spi_rxack_i,
  output logic                    spi_overrun_o,
`endif
  output logic [2:0]              o_dbg_state
);

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_slave_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .spi_clk_i (spi_clk_i), .spi_rst_i (spi_rst_i), .i_async (SCK_SPI),
    .o_level (w_sck_level), .o_rise (w_sck_rise), .o_fall (w_sck_fall)
  );

  // SS idles high, so its chain resets high to avoid a false fall.
  spi_slave_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .spi_clk_i (spi_clk_i), .spi_rst_i (spi_rst_i), .i_async (SS),
    .o_level (w_ss_level), .o_rise (w_ss_rise), .o_fall (w_ss_fall)
  );

  spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .spi_clk_i (spi_clk_i), .spi_rst_i (spi_rst_i), .i_async (MOSI),
    .o_level (w_mosi), .o_rise (w_mosi_rise), .o_fall (w_mosi_fall)
  );

  assign w_unused = ^{w_sck_level, w_mosi_rise, w_mosi_fall};

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DW-1:0]     r_rx_shift;
  logic [DW-1:0]     r_tx_shift;
  logic [2*DW-1:0]   r_reply;
  logic              r_miso;
  logic              r_fbo;
  logic [DW-1:0]     r_rxdata;
  logic              r_rxvalid;
  logic              r_done;
  logic              r_frameerr;

  logic [2*DW-1:0]   w_reply_next;
  logic [DW-1:0]     w_rx_next;
  logic [DW-1:0]     w_tx_shifted;
  logic              w_tx_bit;
  logic              w_first_hi;
  logic              w_first_lo;
  logic              w_word_full;
  logic              w_word0_done;

  // A load coincident with the SS fall must be what word0 transmits.
  assign w_reply_next = spi_txload_i ? spi_txdata_i : r_reply;
  assign w_first_hi   = spi_fbo_i ? w_reply_next[2*DW-1] : w_reply_next[DW];
  assign w_first_lo   = spi_fbo_i ? r_reply[DW-1] : r_reply[0];

  assign w_rx_next    = r_fbo ? {r_rx_shift[DW-2:0], w_mosi}
                              : {w_mosi, r_rx_shift[DW-1:1]};
  assign w_tx_shifted = r_fbo ? {r_tx_shift[DW-2:0], 1'b1}
                              : {1'b1, r_tx_shift[DW-1:1]};
  assign w_tx_bit     = r_fbo ? w_tx_shifted[DW-1] : w_tx_shifted[0];

  assign w_word_full  = (r_bit_cnt == CNT_FULL);
  assign w_word0_done = (r_state == ST_WORD0) && w_ss_rise && w_word_full;

  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '1;
      r_reply    <= '1;
      r_miso     <= 1'b1;
      r_fbo      <= FBO_MSB;
      r_rxdata   <= '0;
      r_rxvalid  <= 1'b0;
      r_done     <= 1'b0;
      r_frameerr <= 1'b0;
    end else begin
      r_rxvalid  <= 1'b0;
      r_done     <= 1'b0;
      r_frameerr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (spi_txload_i) r_reply <= spi_txdata_i;
          if (w_ss_fall && spi_enable_i) begin
            r_state    <= ST_WORD0;
            r_bit_cnt  <= '0;
            r_fbo      <= spi_fbo_i;
            r_tx_shift <= w_reply_next[2*DW-1:DW];
            r_miso     <= w_first_hi;
          end
        end
        ST_WORD0, ST_WORD1: begin
          if (w_ss_rise) begin
            r_miso <= 1'b1;
            if (w_word_full) begin
              // A dropped enable lets the word finish, then parks in IDLE.
              if (r_state == ST_WORD0) begin
                r_rxdata  <= r_rx_shift;
                r_rxvalid <= 1'b1;
                r_gap_cnt <= '0;
                r_state   <= spi_enable_i ? ST_GAP : ST_IDLE;
              end else begin
                r_state   <= spi_enable_i ? ST_DONE : ST_IDLE;
              end
            end else begin
              r_frameerr <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end else begin
            if (w_sck_rise) begin
              r_rx_shift <= w_rx_next;
              if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_sck_fall) begin
              r_tx_shift <= w_tx_shifted;
              r_miso     <= w_tx_bit;
            end
          end
        end
        ST_GAP: begin
          if (!spi_enable_i) begin
            r_state <= ST_IDLE;
          end else if (w_ss_fall) begin
            r_state    <= ST_WORD1;
            r_bit_cnt  <= '0;
            r_fbo      <= spi_fbo_i;
            r_tx_shift <= r_reply[DW-1:0];
            r_miso     <= w_first_lo;
          end else if (r_gap_cnt == GAP_LAST) begin
            r_frameerr <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_pending;
  logic r_overrun;

  // A completing word0 re-arms pending even if acknowledged the same cycle.
  always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
    if (spi_rst_i) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_word0_done) begin
        r_pending <= 1'b1;
        r_overrun <= r_pending & ~spi_rxack_i;
      end else if (spi_rxack_i) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign spi_overrun_o = r_overrun;
`endif

  // MISO is released (1) outside a word or once SS is seen high.
  assign MISO           = (state_is_word(r_state) && !w_ss_level) ? r_miso : 1'b1;
  assign spi_txready_o  = (r_state == ST_IDLE);
  assign spi_rxdata_o   = r_rxdata;
  assign spi_rxvalid_o  = r_rxvalid;
  assign spi_doneflag_o = r_done;
  assign spi_frameerr_o = r_frameerr;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder -- bench for spi_slave_responder acting as the
// SPI master at a 1:4 divider, with a command scoreboard and a vector table.
module tb_spi_slave_responder;

  logic        spi_clk_i = 1'b0;
  logic        spi_rst_i = 1'b1;
  logic        SCK_SPI = 1'b0;
  logic        SS = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        spi_enable_i = 1'b1;
  logic        spi_fbo_i = 1'b1;
  logic [15:0] spi_txdata_i = 16'h0000;
  logic        spi_txload_i = 1'b0;
  logic        spi_txready_o;
  logic [7:0]  spi_rxdata_o;
  logic        spi_rxvalid_o;
  logic        spi_doneflag_o;
  logic        spi_frameerr_o;
  logic [2:0]  o_dbg_state;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic        spi_rxack_i = 1'b0;
  logic        spi_overrun_o;
`endif

  spi_slave_responder #(.DATA_WIDTH(8), .TIMEOUT_CYC(64)) dut (
    .spi_clk_i      (spi_clk_i),
    .spi_rst_i      (spi_rst_i),
    .SCK_SPI        (SCK_SPI),
    .SS             (SS),
    .MOSI           (MOSI),
    .MISO           (MISO),
    .spi_enable_i   (spi_enable_i),
    .spi_fbo_i      (spi_fbo_i),
    .spi_txdata_i   (spi_txdata_i),
    .spi_txload_i   (spi_txload_i),
    .spi_txready_o  (spi_txready_o),
    .spi_rxdata_o   (spi_rxdata_o),
    .spi_rxvalid_o  (spi_rxvalid_o),
    .spi_doneflag_o (spi_doneflag_o),
    .spi_frameerr_o (spi_frameerr_o),
`ifdef SPI_SLAVE_OVERRUN_EN
    .spi_rxack_i    (spi_rxack_i),
    .spi_overrun_o  (spi_overrun_o),
`endif
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 spi_clk_i = ~spi_clk_i;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_rxv    = 0;
  int n_done   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_cmd = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge spi_clk_i) begin
    if (spi_rxvalid_o === 1'b1) begin
      n_rxv++;
      if (exp_q.size() == 0) begin
        check("rxvalid_unexpected", 32'd1, 32'd0);
      end else begin
        check("rxdata", {24'd0, spi_rxdata_o}, {24'd0, exp_q.pop_front()});
      end
    end
    if (spi_doneflag_o === 1'b1) n_done++;
    if (spi_frameerr_o === 1'b1) n_ferr++;
`ifdef SPI_SLAVE_OVERRUN_EN
    if (spi_overrun_o === 1'b1) n_ovr++;
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge spi_clk_i);
    #1;
  endtask

  task automatic load_reply(input logic [15:0] d);
    spi_txdata_i = d;
    spi_txload_i = 1'b1;
    cyc(1);
    spi_txload_i = 1'b0;
  endtask

  // One SS-framed word of nbits; MISO captured at each SCK rise.
  task automatic send_word(input logic fbo, input logic [7:0] cmd, input int nbits,
                           output logic [7:0] got);
    int idx;
    got = 8'h00;
    cyc(2);
    SS = 1'b0;
    cyc(6);
    for (int i = 0; i < nbits; i++) begin
      idx = fbo ? 7 - i : i;
      MOSI = cmd[idx];
      cyc(4);
      got[idx] = MISO;
      SCK_SPI = 1'b1;
      cyc(4);
      SCK_SPI = 1'b0;
    end
    cyc(4);
    SS = 1'b1;
  endtask

  task automatic xfer(input logic fbo, input logic [7:0] cmd, output logic [15:0] reply);
    logic [7:0] hi, lo;
    spi_fbo_i = fbo;
    exp_q.push_back(cmd);
    send_word(fbo, cmd, 8, hi);
    cyc(8);
    send_word(fbo, 8'h00, 8, lo);
    cyc(8);
    reply = {hi, lo};
    last_cmd = cmd;
  endtask

  typedef struct {
    logic        fbo;
    logic        load;
    logic [15:0] reply;
    logic [7:0]  cmd;
    logic [15:0] exp_reply;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test ----------------
  initial begin
    logic [15:0] got16;
    logic [7:0]  got8;
    int d0, f0, v0;

    vecs[0] = '{1'b1, 1'b0, 16'h0000, 8'hC3, 16'hFFFF};
    vecs[1] = '{1'b1, 1'b1, 16'hA55A, 8'h3C, 16'hA55A};
    vecs[2] = '{1'b0, 1'b1, 16'hA55A, 8'h01, 16'hA55A};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 8'hFF, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 16'hBEEF, 8'h80, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 8'h5A, 16'hBEEF};

    cyc(3);
    @(negedge spi_clk_i);
    check("rst_miso", {31'd0, MISO}, 32'd1);
    check("rst_txready", {31'd0, spi_txready_o}, 32'd1);
    check("rst_pulses", {29'd0, spi_rxvalid_o, spi_doneflag_o, spi_frameerr_o}, 32'd0);
    check("rst_rxdata", {24'd0, spi_rxdata_o}, 32'd0);
    check("rst_state", {29'd0, o_dbg_state}, 32'd0);
    spi_rst_i = 1'b0;
    cyc(4);

    // Table: vector 0 runs before any load and must return the reset reply.
    foreach (vecs[k]) begin
      d0 = n_done; f0 = n_ferr;
      check("txready_idle", {31'd0, spi_txready_o}, 32'd1);
      if (vecs[k].load) load_reply(vecs[k].reply);
      xfer(vecs[k].fbo, vecs[k].cmd, got16);
      check($sformatf("vec%0d_reply", k), {16'd0, got16}, {16'd0, vecs[k].exp_reply});
      check($sformatf("vec%0d_done", k), n_done - d0, 32'd1);
      check($sformatf("vec%0d_ferr", k), n_ferr - f0, 32'd0);
    end

    // Random loaded transactions.
    for (int r = 0; r < 4; r++) begin
      logic [15:0] rep;
      logic [7:0]  cmd;
      logic        fbo;
      rep = 16'($urandom_range(0, 65535));
      cmd = 8'($urandom_range(0, 255));
      fbo = 1'($urandom_range(0, 1));
      load_reply(rep);
      xfer(fbo, cmd, got16);
      check("rand_reply", {16'd0, got16}, {16'd0, rep});
    end

    // Latency of rxvalid and doneflag relative to the SS rise.
    load_reply(16'hC33C);
    spi_fbo_i = 1'b1;
    exp_q.push_back(8'h96);
    send_word(1'b1, 8'h96, 8, got8);
    repeat (3) @(negedge spi_clk_i);
    check("rxvalid_early", {31'd0, spi_rxvalid_o}, 32'd0);
    @(negedge spi_clk_i);
    check("rxvalid_at4", {31'd0, spi_rxvalid_o}, 32'd1);
    check("lat_hi", {24'd0, got8}, 32'hC3);
    send_word(1'b1, 8'h00, 8, got8);
    repeat (4) @(negedge spi_clk_i);
    check("done_early", {31'd0, spi_doneflag_o}, 32'd0);
    @(negedge spi_clk_i);
    check("done_at5", {31'd0, spi_doneflag_o}, 32'd1);
    check("lat_lo", {24'd0, got8}, 32'h3C);
    last_cmd = 8'h96;
    cyc(8);

    // Short word0: error, rxdata kept, then a clean frame.
    f0 = n_ferr; v0 = n_rxv;
    send_word(1'b1, 8'h77, 5, got8);
    cyc(8);
    check("abort_ferr", n_ferr - f0, 32'd1);
    check("abort_norxv", n_rxv - v0, 32'd0);
    check("abort_rxdata", {24'd0, spi_rxdata_o}, {24'd0, last_cmd});
    check("abort_state", {29'd0, o_dbg_state}, 32'd0);
    load_reply(16'h5AA5);
    xfer(1'b1, 8'hE1, got16);
    check("after_abort_reply", {16'd0, got16}, 32'h5AA5);

    // Gap timeout after word0.
    d0 = n_done; f0 = n_ferr;
    exp_q.push_back(8'h42);
    send_word(1'b1, 8'h42, 8, got8);
    last_cmd = 8'h42;
    cyc(60);
    check("gap_waiting", {31'd0, spi_txready_o}, 32'd0);
    cyc(20);
    check("timeout_ferr", n_ferr - f0, 32'd1);
    check("timeout_nodone", n_done - d0, 32'd0);
    check("timeout_txready", {31'd0, spi_txready_o}, 32'd1);

    // Enable low: the bus is ignored, MISO stays high.
    spi_enable_i = 1'b0;
    v0 = n_rxv;
    send_word(1'b1, 8'hAA, 8, got8);
    cyc(8);
    check("disabled_miso", {24'd0, got8}, 32'hFF);
    check("disabled_norxv", n_rxv - v0, 32'd0);
    spi_enable_i = 1'b1;

    // Reset in the middle of word1.
    load_reply(16'h0F0F);
    d0 = n_done; f0 = n_ferr;
    exp_q.push_back(8'h5A);
    send_word(1'b1, 8'h5A, 8, got8);
    cyc(8);
    SS = 1'b0;
    cyc(6);
    for (int b = 0; b < 3; b++) begin
      MOSI = b[0];
      cyc(4);
      SCK_SPI = 1'b1;
      cyc(4);
      SCK_SPI = 1'b0;
    end
    check("word1_active", {29'd0, o_dbg_state}, 32'd3);
    spi_rst_i = 1'b1;
    #1;
    check("midrst_miso", {31'd0, MISO}, 32'd1);
    check("midrst_pulses", {29'd0, spi_rxvalid_o, spi_doneflag_o, spi_frameerr_o}, 32'd0);
    check("midrst_state", {29'd0, o_dbg_state}, 32'd0);
    SS = 1'b1;
    SCK_SPI = 1'b0;
    cyc(2);
    spi_rst_i = 1'b0;
    load_reply(16'h6996);
    cyc(4);
    check("midrst_no_done", n_done - d0, 32'd0);
    check("midrst_no_ferr", n_ferr - f0, 32'd0);
    check("midrst_rxdata", {24'd0, spi_rxdata_o}, 32'd0);
    xfer(1'b0, 8'h24, got16);
    check("post_rst_reply", {16'd0, got16}, 32'h6996);

`ifdef SPI_SLAVE_OVERRUN_EN
    spi_rxack_i = 1'b1;
    cyc(1);
    spi_rxack_i = 1'b0;
    v0 = n_ovr;
    xfer(1'b1, 8'h11, got16);
    xfer(1'b1, 8'h22, got16);
    check("overrun_once", n_ovr - v0, 32'd1);
    check("overrun_rxdata", {24'd0, spi_rxdata_o}, 32'h22);
`endif

    cyc(4);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
